sync_fifo_wr_arbiter: RTL and testbench
=======================================

Name: sync_fifo_wr_arbiter

Overview:
- Shares the write port of one synchronous FIFO (8-bit × 16 by default) among N producer requesters.
- Grants are round-robin and burst-based. A grant is held until the requester's last beat or until MAX_BURST beats, whichever comes first.
- The block sits directly in front of the FIFO and drives its wr_en/data_in. It observes the FIFO full flag for back-pressure.

Parameters:
- N_REQ, 4, number of requesters (2..8)
- DATA_WIDTH, 8, beat width; equals the FIFO data width
- MAX_BURST, 8, maximum beats per grant (1..256)
- ID_WIDTH, $clog2(N_REQ), width of grant_id

Ports:
- clk  input  1  single clock, rising edge
- rst  input  1  asynchronous, active-high reset
- req_valid  input  N_REQ  per-requester beat valid
- req_data  input  N_REQ*DATA_WIDTH  packed beats; requester i occupies bits [i*DATA_WIDTH +: DATA_WIDTH]
- req_last  input  N_REQ  marks the final beat of a burst
- req_ready  output  N_REQ  per-requester accept
- fifo_full  input  1  FIFO full flag
- fifo_wr_en  output  1  FIFO write enable
- fifo_wr_data  output  DATA_WIDTH  FIFO write data
- grant_id  output  ID_WIDTH  index of the current owner
- busy  output  1  high while a grant is held
- burst_done  output  1  one-cycle pulse after a grant ends

Behaviour:
- Reset state (rst high, asynchronous):
  - state=IDLE, grant_id=0, last_grant=N_REQ-1 (so requester 0 has top priority after reset), beat_cnt=0, burst_done=0.
  - busy, req_ready and fifo_wr_en are all 0.
- FSM states: IDLE and BURST.
- IDLE:
  - If any req_valid is high, the next owner is the first set bit scanning from last_grant+1 upward, wrapping modulo N_REQ.
  - On the next edge: grant_id<=winner, last_grant<=winner, beat_cnt<=0, state<=BURST.
  - No transfer occurs in IDLE. Grant latency is 1 cycle from valid to ready.
  - If no req_valid is high, the block stays in IDLE.
- BURST:
  - busy=1.
  - req_ready[grant_id] = ~fifo_full; every other req_ready bit is 0.
  - fifo_wr_en = req_valid[grant_id] & ~fifo_full. This path is combinational with zero latency.
  - fifo_wr_data = req_data slice of grant_id, always driven in BURST.
  - In IDLE, fifo_wr_data = 0.
- Transfer: fifo_wr_en=1 at a clock edge. Each transfer increments beat_cnt.
- Burst end, on a transfer where req_last[grant_id]=1 OR beat_cnt==MAX_BURST-1:
  - state<=IDLE, burst_done<=1 for one cycle, beat_cnt<=0.
- Bubbles:
  - A low req_valid from the owner during BURST does not release the grant.
  - beat_cnt does not advance.
- fifo_full high:
  - No transfer.
  - req_ready of the owner is 0.
  - State is held indefinitely; there is no timeout.
- Simultaneous events:
  - req_last and MAX_BURST reached on the same beat: single end, one burst_done pulse.
  - New requests arriving in BURST: ignored until the return to IDLE.
  - burst_done=1 and arbitration in IDLE can occur in the same cycle.
- Fairness:
  - The owner of a truncated burst (MAX_BURST reached, req_last not seen) re-enters arbitration with lowest priority.
  - It continues its burst at a later grant.
- Writes never occur while fifo_full=1, so FIFO overflow is impossible by construction.
- Reset mid-burst:
  - Immediate return to IDLE; all outputs go to their reset values.
  - Partially written data remains in the FIFO. The FIFO has its own reset.
- beat_cnt width is $clog2(MAX_BURST)+1 bits and never exceeds MAX_BURST-1.

Test Plan:
- Single requester:
  - Stimulus: after reset, req_valid=4'b0100, 3 beats 0x11, 0x22, 0x33 with last on 0x33, FIFO empty.
  - Response: grant_id=2 one cycle later; fifo_wr_en high for exactly 3 consecutive cycles with data 0x11, 0x22, 0x33; burst_done pulse the cycle after; busy falls.
- Round-robin:
  - Stimulus: all four requesters continuously valid, each burst 2 beats.
  - Response: grant order 0, 1, 2, 3, 0; each grant writes 2 beats; a 1-cycle IDLE gap between grants.
- MAX_BURST truncation:
  - Stimulus: MAX_BURST=8, requester 1 sends 10 beats without last, requester 3 also valid.
  - Response: 8 beats from requester 1, then grant to 3, then requester 1 resumes with the remaining 2 beats.
- Back-pressure:
  - Stimulus: fifo_full asserted for 5 cycles mid-burst of requester 0.
  - Response: req_ready[0]=0 and fifo_wr_en=0 during those cycles; beat_cnt frozen; grant held; the burst completes correctly after full drops.
- Valid bubble:
  - Stimulus: the owner deasserts req_valid for 3 cycles mid-burst while others are valid.
  - Response: grant is not released; no writes during the bubble; no other req_ready asserts.
- Reset mid-burst:
  - Stimulus: rst pulsed on beat 2 of a 5-beat burst from requester 3.
  - Response: asynchronous return to IDLE, all outputs 0; first grant after reset goes to requester 0 if it is valid.

Source files
------------

// File: rtl/sync_fifo_wr_arbiter.sv
// Round-robin, burst-granular arbiter sharing one synchronous FIFO write port
// among N_REQ producers; back-pressured by the FIFO full flag.
module sync_fifo_wr_arbiter #(
    parameter int N_REQ      = 4,
    parameter int DATA_WIDTH = 8,
    parameter int MAX_BURST  = 8,
    parameter int ID_WIDTH   = $clog2(N_REQ)
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [N_REQ-1:0]            req_valid,
    input  logic [N_REQ*DATA_WIDTH-1:0] req_data,
    input  logic [N_REQ-1:0]            req_last,
    output logic [N_REQ-1:0]            req_ready,
    input  logic                        fifo_full,
    output logic                        fifo_wr_en,
    output logic [DATA_WIDTH-1:0]       fifo_wr_data,
    output logic [ID_WIDTH-1:0]         grant_id,
    output logic                        busy,
    output logic                        burst_done
);

    localparam int CNT_W = $clog2(MAX_BURST) + 1;

    typedef enum logic {
        IDLE,
        BURST
    } state_t;

    state_t              state, state_nxt;
    logic [ID_WIDTH-1:0] grant_nxt;
    logic [ID_WIDTH-1:0] last_grant, last_grant_nxt;
    logic [CNT_W-1:0]    beat_cnt, beat_cnt_nxt;
    logic                burst_done_nxt;

    logic                  own_valid;
    logic                  own_last;
    logic [DATA_WIDTH-1:0] own_data;
    logic [N_REQ-1:0]      own_onehot;

    // First valid requester strictly after 'last', wrapping modulo N_REQ.
    function automatic logic [ID_WIDTH-1:0] rr_pick(
        input logic [N_REQ-1:0]    v,
        input logic [ID_WIDTH-1:0] last
    );
        logic [ID_WIDTH-1:0] w;
        logic                found;
        int                  idx;
        w     = '0;
        found = 1'b0;
        for (int k = 1; k <= N_REQ; k++) begin
            idx = (int'(last) + k) % N_REQ;
            if (!found && v[idx]) begin
                w     = ID_WIDTH'(idx);
                found = 1'b1;
            end
        end
        return w;
    endfunction

    always_comb begin
        own_valid  = 1'b0;
        own_last   = 1'b0;
        own_data   = '0;
        own_onehot = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (grant_id == ID_WIDTH'(i)) begin
                own_valid     = req_valid[i];
                own_last      = req_last[i];
                own_data      = req_data[i*DATA_WIDTH +: DATA_WIDTH];
                own_onehot[i] = 1'b1;
            end
        end
    end

    always_comb begin
        state_nxt      = state;
        grant_nxt      = grant_id;
        last_grant_nxt = last_grant;
        beat_cnt_nxt   = beat_cnt;
        burst_done_nxt = 1'b0;
        busy           = 1'b0;
        req_ready      = '0;
        fifo_wr_en     = 1'b0;
        fifo_wr_data   = '0;
        case (state)
            IDLE: begin
                if (|req_valid) begin
                    grant_nxt      = rr_pick(req_valid, last_grant);
                    last_grant_nxt = grant_nxt;
                    beat_cnt_nxt   = '0;
                    state_nxt      = BURST;
                end
            end
            BURST: begin
                busy         = 1'b1;
                req_ready    = fifo_full ? '0 : own_onehot;
                fifo_wr_en   = own_valid & ~fifo_full;
                fifo_wr_data = own_data;
                // A beat that is both last and the MAX_BURST-th ends the grant once.
                if (fifo_wr_en) begin
                    if (own_last || beat_cnt == CNT_W'(MAX_BURST - 1)) begin
                        state_nxt      = IDLE;
                        beat_cnt_nxt   = '0;
                        burst_done_nxt = 1'b1;
                    end else begin
                        beat_cnt_nxt = beat_cnt + CNT_W'(1);
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            grant_id   <= '0;
            last_grant <= ID_WIDTH'(N_REQ - 1);
            beat_cnt   <= '0;
            burst_done <= 1'b0;
        end else begin
            state      <= state_nxt;
            grant_id   <= grant_nxt;
            last_grant <= last_grant_nxt;
            beat_cnt   <= beat_cnt_nxt;
            burst_done <= burst_done_nxt;
        end
    end

endmodule

// File: tb/tb_sync_fifo_wr_arbiter.sv
// Directed bench for sync_fifo_wr_arbiter: per-cycle comparison against a
// behavioural arbiter model plus literal write-stream expectations per scenario.
module tb_sync_fifo_wr_arbiter;

    localparam int N    = 4;
    localparam int DW   = 8;
    localparam int MAXB = 8;
    localparam int IDW  = 2;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [N-1:0]      req_valid = '0;
    logic [N*DW-1:0]   req_data  = '0;
    logic [N-1:0]      req_last  = '0;
    logic [N-1:0]      req_ready;
    logic              fifo_full = 1'b0;
    logic              fifo_wr_en;
    logic [DW-1:0]     fifo_wr_data;
    logic [IDW-1:0]    grant_id;
    logic              busy;
    logic              burst_done;

    int n_vec  = 0;
    int n_miss = 0;

    sync_fifo_wr_arbiter #(
        .N_REQ(N), .DATA_WIDTH(DW), .MAX_BURST(MAXB), .ID_WIDTH(IDW)
    ) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_data(req_data), .req_last(req_last),
        .req_ready(req_ready), .fifo_full(fifo_full),
        .fifo_wr_en(fifo_wr_en), .fifo_wr_data(fifo_wr_data),
        .grant_id(grant_id), .busy(busy), .burst_done(burst_done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Producer sources: per-requester beat lists {last, data}.
    logic [8:0]   mem [N][64];
    int           head [N];
    int           tail [N];
    logic [N-1:0] en  = '1;
    logic [N-1:0] acc = '0;

    initial begin
        for (int i = 0; i < N; i++) begin
            head[i] = 0;
            tail[i] = 0;
        end
    end

    task automatic push(input int r, input logic [7:0] d, input logic l);
        mem[r][tail[r]] = {l, d};
        tail[r]++;
    endtask

    always @(negedge clk) acc = req_ready & req_valid;

    always begin
        @(posedge clk);
        #1;
        for (int i = 0; i < N; i++)
            if (acc[i] && head[i] < tail[i]) head[i]++;
        for (int i = 0; i < N; i++) begin
            if (en[i] && head[i] < tail[i]) begin
                req_valid[i]          = 1'b1;
                req_data[i*DW +: DW]  = mem[i][head[i]][7:0];
                req_last[i]           = mem[i][head[i]][8];
            end else begin
                req_valid[i]          = 1'b0;
                req_data[i*DW +: DW]  = '0;
                req_last[i]           = 1'b0;
            end
        end
    end

    // Behavioural model: owner index (-1 when nobody holds the port).
    int   m_owner = -1;
    int   m_gid   = 0;
    int   m_lastg = N - 1;
    int   m_cnt   = 0;
    logic m_done  = 1'b0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_owner = -1;
            m_gid   = 0;
            m_lastg = N - 1;
            m_cnt   = 0;
            m_done  = 1'b0;
        end else begin
            m_done = 1'b0;
            if (m_owner < 0) begin
                for (int k = 1; k <= N; k++) begin
                    int idx;
                    idx = (m_lastg + k) % N;
                    if (m_owner < 0 && req_valid[idx]) m_owner = idx;
                end
                if (m_owner >= 0) begin
                    m_gid   = m_owner;
                    m_lastg = m_owner;
                    m_cnt   = 0;
                end
            end else if (req_valid[m_owner] && !fifo_full) begin
                m_cnt++;
                if (req_last[m_owner] || m_cnt == MAXB) begin
                    m_owner = -1;
                    m_cnt   = 0;
                    m_done  = 1'b1;
                end
            end
        end
    end

    always @(negedge clk) begin
        logic [N-1:0]  e_ready;
        logic          e_wr;
        logic [DW-1:0] e_data;
        e_ready = '0;
        e_wr    = 1'b0;
        e_data  = '0;
        if (m_owner >= 0) begin
            if (!fifo_full) e_ready[m_owner] = 1'b1;
            e_wr   = req_valid[m_owner] && !fifo_full;
            e_data = req_data[m_owner*DW +: DW];
        end
        chk("busy",       32'(busy),         32'(m_owner >= 0));
        chk("req_ready",  32'(req_ready),    32'(e_ready));
        chk("fifo_wr_en", 32'(fifo_wr_en),   32'(e_wr));
        chk("wr_data",    32'(fifo_wr_data), 32'(e_data));
        chk("grant_id",   32'(grant_id),     32'(m_gid));
        chk("burst_done", 32'(burst_done),   32'(m_done));
    end

    // Observed FIFO write stream {grant_id, data}.
    logic [11:0] wlog  [$];
    logic [11:0] exp_q [$];
    int          log_base = 0;

    always @(negedge clk)
        if (fifo_wr_en === 1'b1) wlog.push_back({2'b00, grant_id, fifo_wr_data});

    task automatic expw(input int g, input logic [7:0] d);
        logic [3:0] g4;
        g4 = 4'(g);
        exp_q.push_back({g4, d});
    endtask

    task automatic check_log(input string nm);
        chk({nm, "_count"}, 32'(wlog.size() - log_base), 32'(exp_q.size()));
        for (int k = 0; k < exp_q.size(); k++) begin
            if (log_base + k < wlog.size())
                chk({nm, "_beat"}, 32'(wlog[log_base + k]), 32'(exp_q[k]));
        end
        log_base = wlog.size();
        exp_q.delete();
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick(2);
        rst = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit got;
        tick(3);
        rst = 1'b0;
        tick(1);

        // Single requester, 3-beat burst
        push(2, 8'h11, 1'b0); push(2, 8'h22, 1'b0); push(2, 8'h33, 1'b1);
        tick(10);
        expw(2, 8'h11); expw(2, 8'h22); expw(2, 8'h33);
        check_log("single");

        // Round-robin from a fresh reset
        do_reset();
        for (int r = 0; r < N; r++) begin
            push(r, 8'((r << 4) | 1), 1'b0);
            push(r, 8'((r << 4) | 2), 1'b1);
        end
        push(0, 8'h05, 1'b0); push(0, 8'h06, 1'b1);
        tick(30);
        for (int r = 0; r < N; r++) begin
            expw(r, 8'((r << 4) | 1));
            expw(r, 8'((r << 4) | 2));
        end
        expw(0, 8'h05); expw(0, 8'h06);
        check_log("round_robin");

        // MAX_BURST truncation: requester 1 sends 10 beats, last only on the 10th
        for (int b = 0; b < 10; b++) push(1, 8'(8'hA0 + b), b == 9);
        push(3, 8'hB0, 1'b0); push(3, 8'hB1, 1'b1);
        tick(40);
        for (int b = 0; b < 8; b++) expw(1, 8'(8'hA0 + b));
        expw(3, 8'hB0); expw(3, 8'hB1);
        expw(1, 8'hA8); expw(1, 8'hA9);
        check_log("truncation");

        // Back-pressure mid-burst of requester 0
        for (int b = 0; b < 5; b++) push(0, 8'(8'hC0 + b), b == 4);
        tick(4);
        fifo_full = 1'b1;
        tick(5);
        fifo_full = 1'b0;
        tick(15);
        for (int b = 0; b < 5; b++) expw(0, 8'(8'hC0 + b));
        check_log("backpressure");

        // Owner bubble with another requester waiting
        for (int b = 0; b < 4; b++) push(1, 8'(8'hD0 + b), b == 3);
        push(2, 8'hE0, 1'b1);
        tick(4);
        en[1] = 1'b0;
        tick(3);
        en[1] = 1'b1;
        tick(15);
        for (int b = 0; b < 4; b++) expw(1, 8'(8'hD0 + b));
        expw(2, 8'hE0);
        check_log("bubble");

        // Reset on beat 2 of a 5-beat burst from requester 3
        for (int b = 0; b < 5; b++) push(3, 8'(8'hF0 + b), b == 4);
        push(0, 8'h77, 1'b1);
        got = 1'b0;
        for (int t = 0; t < 20 && !got; t++) begin
            tick(1);
            if (wlog.size() - log_base >= 2) got = 1'b1;
        end
        chk("reset_wait_beats", 32'(got), 32'd1);
        #1;
        rst = 1'b1;
        #1;
        chk("rst_busy",      32'(busy),       32'd0);
        chk("rst_wr_en",     32'(fifo_wr_en), 32'd0);
        chk("rst_ready",     32'(req_ready),  32'd0);
        chk("rst_grant_id",  32'(grant_id),   32'd0);
        chk("rst_wr_data",   32'(fifo_wr_data), 32'd0);
        expw(3, 8'hF0); expw(3, 8'hF1);
        check_log("pre_reset");
        tick(2);
        rst = 1'b0;
        tick(20);
        expw(0, 8'h77);
        expw(3, 8'hF2); expw(3, 8'hF3); expw(3, 8'hF4);
        check_log("post_reset");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
